// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline controller and the datapath/hazard/memory blocks.
// The controller connects through the slave modport; the driver of hazard/branch/memory flags uses master.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             hazard_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             if_id_flush_o;
  logic             id_ex_write_o;
  logic             id_ex_bubble_o;
  logic             ex_mem_write_o;
  logic             mem_wb_bubble_o;
  logic             dmem_valid_o;
  logic             halt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport slave (
    input  hazard_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o, id_ex_bubble_o,
           ex_mem_write_o, mem_wb_bubble_o, dmem_valid_o, halt_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output hazard_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o, id_ex_bubble_o,
           ex_mem_write_o, mem_wb_bubble_o, dmem_valid_o, halt_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline stall/flush controller with data-memory wait and timeout halt.
// Optional statistics counters are built only when PIPE_STAT_EN is defined.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pipe_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              freeze;
  logic              pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic              ex_mem_write, mem_wb_bubble, dmem_valid;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    freeze    = 1'b0;
    case (state)
      RUN: begin
        // same-cycle ack completes the access without stalling
        if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = '0;
          freeze    = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          state_nxt = RUN;
        end else begin
          freeze = 1'b1;
          if (wait_cnt >= TMO_LAST) state_nxt = HALT;
          else                      wait_nxt  = wait_cnt + WAIT_W'(1);
        end
      end
      HALT:    freeze = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  // All controls are forced low while reset is held, independent of the clock.
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b0;
    mem_wb_bubble = 1'b0;
    dmem_valid    = 1'b0;
    if (rst_i) begin
      case (state)
        RUN:      dmem_valid = bus.dmem_req_i;
        MEM_WAIT: dmem_valid = 1'b1;
        default:  dmem_valid = 1'b0;
      endcase
      if (freeze) begin
        mem_wb_bubble = 1'b1;
      end else if (bus.hazard_i) begin
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_write = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = bus.branch_taken_i | bus.jump_i;
      end
    end
  end

  assign bus.pc_write_o      = pc_write;
  assign bus.if_id_write_o   = if_id_write;
  assign bus.if_id_flush_o   = if_id_flush;
  assign bus.id_ex_write_o   = id_ex_write;
  assign bus.id_ex_bubble_o  = id_ex_bubble;
  assign bus.ex_mem_write_o  = ex_mem_write;
  assign bus.mem_wb_bubble_o = mem_wb_bubble;
  assign bus.dmem_valid_o    = dmem_valid;
  assign bus.halt_o          = (state == HALT);

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && stall_cnt != '1)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a behavioural model, plus directed literal checks.
module tb_pipe_ctrl;
  localparam int TMO = 4;
  localparam int CW  = 4;
`ifdef PIPE_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // model: mode 0=running, 1=waiting on memory, 2=halted
  int m_mode, m_wait, m_stall, m_flush;
  int n_mode, n_wait, n_stall, n_flush;

  function automatic int sat(input int v);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  always @(negedge clk) begin
    logic [8:0] e, g;
    bit frz, pw, fl;
    g = {bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o, bus.id_ex_write_o,
         bus.id_ex_bubble_o, bus.ex_mem_write_o, bus.mem_wb_bubble_o, bus.dmem_valid_o, bus.halt_o};
    if (!rst) begin
      e = '0;
      n_mode = 0; n_wait = 0; n_stall = 0; n_flush = 0;
      chk("rst_ctrl", 32'(g), 32'(e));
      chk("rst_stall", 32'(bus.stall_cnt_o), 0);
      chk("rst_flush", 32'(bus.flush_cnt_o), 0);
    end else begin
      frz = (m_mode == 2) || (m_mode == 0 && bus.dmem_req_i && !bus.dmem_ack_i) ||
            (m_mode == 1 && !bus.dmem_ack_i);
      if (frz)               e = 9'b0000_0010_0;
      else if (bus.hazard_i) e = 9'b0001_1100_0;
      else if (bus.branch_taken_i || bus.jump_i) e = 9'b1111_0100_0;
      else                   e = 9'b1101_0100_0;
      e[1] = (m_mode == 0) ? bus.dmem_req_i : (m_mode == 1);
      e[0] = (m_mode == 2);
      chk("ctrl", 32'(g), 32'(e));
      chk("stall_cnt", 32'(bus.stall_cnt_o), STAT ? m_stall : 0);
      chk("flush_cnt", 32'(bus.flush_cnt_o), STAT ? m_flush : 0);
      pw = e[8]; fl = e[6];
      n_stall = sat(m_stall + (pw ? 0 : 1));
      n_flush = sat(m_flush + (fl ? 1 : 0));
      n_mode = m_mode; n_wait = m_wait;
      if (m_mode == 0 && bus.dmem_req_i && !bus.dmem_ack_i) begin
        n_mode = 1; n_wait = 0;
      end else if (m_mode == 1) begin
        if (bus.dmem_ack_i) n_mode = 0;
        else if (m_wait + 1 >= TMO) n_mode = 2;
        else n_wait = m_wait + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_mode = n_mode; m_wait = n_wait; m_stall = n_stall; m_flush = n_flush;
    end
  end

  task automatic drive(input bit h, input bit b, input bit j, input bit r, input bit a);
    @(posedge clk);
    #1;
    bus.hazard_i = h; bus.branch_taken_i = b; bus.jump_i = j;
    bus.dmem_req_i = r; bus.dmem_ack_i = a;
  endtask

  initial begin
    bus.hazard_i = 0; bus.branch_taken_i = 0; bus.jump_i = 0;
    bus.dmem_req_i = 0; bus.dmem_ack_i = 0;
    m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    n_mode = 0; n_wait = 0; n_stall = 0; n_flush = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_pw", 32'(bus.pc_write_o), 0);
    chk("lit_rst_dv", 32'(bus.dmem_valid_o), 0);
    chk("lit_rst_halt", 32'(bus.halt_o), 0);
    @(posedge clk); #1; rst = 1'b1;
    #3 chk("lit_rel_pw", 32'(bus.pc_write_o), 1);

    // single-cycle load-use hazard
    drive(1, 0, 0, 0, 0);
    #3 chk("lit_hz_pw", 32'(bus.pc_write_o), 0);
    chk("lit_hz_bub", 32'(bus.id_ex_bubble_o), 1);
    chk("lit_hz_ifw", 32'(bus.if_id_write_o), 0);
    drive(0, 0, 0, 0, 0);
    #3 chk("lit_hz_stall", 32'(bus.stall_cnt_o), STAT ? 1 : 0);

    // branch coincident with hazard is dropped, then taken next cycle
    drive(1, 1, 0, 0, 0);
    #3 chk("lit_hb_flush", 32'(bus.if_id_flush_o), 0);
    drive(0, 1, 0, 0, 0);
    #3 chk("lit_br_flush", 32'(bus.if_id_flush_o), 1);
    drive(0, 0, 0, 0, 0);
    #3 chk("lit_br_fcnt", 32'(bus.flush_cnt_o), STAT ? 1 : 0);
    chk("lit_br_scnt", 32'(bus.stall_cnt_o), STAT ? 2 : 0);

    // three frozen cycles then ack
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      #3 chk("lit_mw_bub", 32'(bus.mem_wb_bubble_o), 1);
      chk("lit_mw_pw", 32'(bus.pc_write_o), 0);
    end
    drive(0, 0, 0, 1, 1);
    #3 chk("lit_ack_pw", 32'(bus.pc_write_o), 1);
    chk("lit_ack_bub", 32'(bus.mem_wb_bubble_o), 0);
    drive(0, 0, 0, 0, 0);
    #3 chk("lit_run_dv", 32'(bus.dmem_valid_o), 0);

    // timeout: one entry cycle plus TMO waiting cycles, then halt
    for (int i = 0; i < 1 + TMO; i++) drive(0, 0, 0, 1, 0);
    #3 chk("lit_pre_halt", 32'(bus.halt_o), 0);
    chk("lit_pre_dv", 32'(bus.dmem_valid_o), 1);
    drive(0, 0, 0, 1, 1);
    #3 chk("lit_halt", 32'(bus.halt_o), 1);
    chk("lit_halt_dv", 32'(bus.dmem_valid_o), 0);
    chk("lit_halt_pw", 32'(bus.pc_write_o), 0);
    drive(0, 0, 0, 0, 1);
    #3 chk("lit_halt_sticky", 32'(bus.halt_o), 1);
    @(posedge clk); #1; rst = 1'b0;
    #1 chk("lit_halt_clr", 32'(bus.halt_o), 0);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;

    // asynchronous reset mid memory wait
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    #1 rst = 1'b0;
    #1 chk("lit_async_dv", 32'(bus.dmem_valid_o), 0);
    chk("lit_async_bub", 32'(bus.mem_wb_bubble_o), 0);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #3 chk("lit_post_we", 32'({bus.pc_write_o, bus.if_id_write_o, bus.id_ex_write_o, bus.ex_mem_write_o}), 32'hf);

    // randomized traffic with occasional reset pulses
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4);
      if ($urandom_range(0, 59) == 0) rst = 1'b0;
      else rst = 1'b1;
    end
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive MEM_WAIT cycles without acknowledge before halting.
REQ-002 Parameter CNT_W, default 32: width of the statistics counters.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 hazard_i  input  1  load-use hazard flag from the hazard detection unit.
REQ-006 branch_taken_i  input  1  branch resolved taken in ID.
REQ-007 jump_i  input  1  jump decoded in ID.
REQ-008 dmem_req_i  input  1  MEM stage holds a load or store.
REQ-009 dmem_ack_i  input  1  data memory completes the outstanding access.
REQ-010 pc_write_o  output  1  PC update enable.
REQ-011 if_id_write_o  output  1  IF/ID register write enable.
REQ-012 if_id_flush_o  output  1  clear IF/ID to a NOP.
REQ-013 id_ex_write_o  output  1  ID/EX register write enable.
REQ-014 id_ex_bubble_o  output  1  load ID/EX with zero control signals.
REQ-015 ex_mem_write_o  output  1  EX/MEM register write enable.
REQ-016 mem_wb_bubble_o  output  1  load MEM/WB with zero control signals.
REQ-017 dmem_valid_o  output  1  request valid toward data memory.
REQ-018 halt_o  output  1  sticky memory-timeout indication.
REQ-019 stall_cnt_o  output  CNT_W  cycles with pc_write_o low.
REQ-020 flush_cnt_o  output  CNT_W  cycles with if_id_flush_o high.

Function
REQ-021 State machine SHALL have exactly three states: RUN, MEM_WAIT and HALT.
REQ-022 Freeze condition SHALL be (RUN and dmem_req_i and not dmem_ack_i) or (MEM_WAIT and not dmem_ack_i).
REQ-023 During freeze: pc_write_o, if_id_write_o, id_ex_write_o and ex_mem_write_o SHALL be 0; mem_wb_bubble_o SHALL be 1; flush and id_ex_bubble_o SHALL be 0.
REQ-024 Without freeze, if hazard_i is high: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; all other write enables SHALL be 1 and if_id_flush_o SHALL be 0.
REQ-025 Without freeze or hazard, if branch_taken_i or jump_i is high: if_id_flush_o=1 and all write enables SHALL be 1.
REQ-026 With no condition active, all write enables SHALL be 1 and all bubble and flush outputs SHALL be 0.
REQ-027 Priority SHALL be freeze > hazard > branch/jump; a branch coincident with a hazard is dropped and re-evaluated the next cycle.
REQ-028 RUN→MEM_WAIT SHALL occur when dmem_req_i=1 and dmem_ack_i=0; an ack in the same cycle as the request causes no stall and no transition.
REQ-029 MEM_WAIT→RUN SHALL occur on the cycle dmem_ack_i=1; that cycle is not frozen and is evaluated per REQ-024..026.
REQ-030 A wait counter SHALL clear on MEM_WAIT entry and increment on each MEM_WAIT cycle without ack.
REQ-031 When the wait counter reaches MEM_TIMEOUT without ack, the block SHALL enter HALT on the next edge and set halt_o.
REQ-032 dmem_valid_o SHALL equal dmem_req_i in RUN, 1 in MEM_WAIT and 0 in HALT.
REQ-033 HALT SHALL freeze per REQ-023 regardless of inputs and SHALL be left only by reset; dmem_ack_i is ignored in HALT.

Reset
REQ-034 While rst_i=0: state=RUN, wait counter=0, halt_o=0, both statistics counters=0, all write, bubble, flush and dmem_valid_o outputs=0.
REQ-035 Reset asserted during MEM_WAIT or HALT SHALL abort immediately; after release the block starts in RUN.

Configuration
REQ-036 With macro PIPE_STAT_EN defined, stall_cnt_o and flush_cnt_o SHALL count per REQ-019/020 and saturate at all-ones.
REQ-037 Without PIPE_STAT_EN, stall_cnt_o and flush_cnt_o SHALL be constant 0 and no counter flops are present; all other behaviour is identical.

Verification
REQ-038 hazard_i=1 for one cycle in RUN -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 that cycle; stall_cnt_o increments by 1.
REQ-039 dmem_req_i=1, dmem_ack_i=0 for 3 cycles, then ack -> 3 frozen cycles with mem_wb_bubble_o=1; full advance on the ack cycle; state returns to RUN.
REQ-040 hazard_i=1 and branch_taken_i=1 in the same cycle -> stall only, if_id_flush_o=0; with branch held the next cycle and hazard_i=0 -> if_id_flush_o=1, flush_cnt_o=1.
REQ-041 MEM_TIMEOUT=4, request with no ack -> halt_o=1 after 4 wait cycles; dmem_valid_o=0; late ack ignored; only rst_i=0 clears halt_o.
REQ-042 rst_i=0 asserted mid-MEM_WAIT -> all outputs 0 asynchronously; after release with no inputs active, all write enables are 1 on the first cycle.
